ras_restore_ctrl: RTL
=====================

# ras_restore_ctrl

Controller sitting between the frontend branch predictor and the return address stack (RAS). It forwards speculative call/return push/pop requests to the RAS. It keeps a committed shadow copy of the stack, updated from the commit stage. On a branch mispredict it flushes the RAS and replays the shadow entries into it, oldest first, stalling the frontend until the RAS again holds the architecturally committed call chain.

## Interface
Parameters:
- DEPTH, 2, entries in the RAS and in the shadow stack (≥2); must match the RAS instance.
- VLEN, riscv::VLEN, return-address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  context clear: empty shadow and RAS
- mispredict_i  in  1  backend mispredict: start restore
- fe_push_i  in  1  frontend speculative call (push)
- fe_pop_i  in  1  frontend speculative return (pop)
- fe_data_i  in  VLEN  return address for fe_push_i
- fe_ready_o  out  1  frontend request accepted this cycle
- commit_call_i  in  1  call instruction committed
- commit_ret_i  in  1  return instruction committed
- commit_data_i  in  VLEN  return address of committed call
- ras_flush_o  out  1  to RAS flush_i
- ras_push_o  out  1  to RAS push_i
- ras_pop_o  out  1  to RAS pop_i
- ras_data_o  out  VLEN  to RAS data_i
- restore_busy_o  out  1  high while in RESTORE

## Operation
- Shadow stack: DEPTH × VLEN entries plus count `cnt` (0..DEPTH). It has the same semantics as the RAS:
  - Push shifts entries toward DEPTH-1 and drops the oldest; `cnt` saturates at DEPTH.
  - Pop shifts toward 0; `cnt` decrements and stays at 0 when already 0.
  - Push+pop in the same cycle replaces entry 0 and leaves `cnt` unchanged.
- Commit updates are applied to the live shadow in every state.
- FSM states: IDLE, RESTORE.
- IDLE behaviour:
  - fe_ready_o=1.
  - ras_push_o=fe_push_i, ras_pop_o=fe_pop_i, ras_data_o=fe_data_i, combinational pass-through.
- mispredict_i while in IDLE or RESTORE:
  - That cycle: ras_flush_o=1, ras_push_o=ras_pop_o=0, fe_ready_o=0, and the frontend request is dropped.
  - Snapshot shadow (including any same-cycle commit update) into `snap`, with `rcnt`=post-update `cnt`.
  - Next state is RESTORE if `rcnt`>0, else IDLE.
- RESTORE behaviour:
  - Each cycle: ras_push_o=1, ras_data_o=snap[rcnt-1], rcnt decrements.
  - On the cycle pushing snap[0], next state is IDLE.
  - fe_ready_o=0 and fe_* requests are ignored.
- A new mispredict_i during RESTORE restarts the sequence (flush, re-snapshot).
- clear_i has the highest priority:
  - ras_flush_o=1, shadow `cnt`=0 and entries zeroed, state IDLE, fe_ready_o=0 that cycle.
  - Commits in the same cycle are discarded.
- RAS state produced by a restore equals the shadow at snapshot time.
- Commits arriving during RESTORE reach the shadow only, not the RAS. This imprecision is accepted.

## Timing
- Reset values:
  - state IDLE, shadow and snap zero, cnt=rcnt=0.
  - fe_ready_o=1, restore_busy_o=0.
  - ras_flush_o/push_o/pop_o=0 absent inputs, ras_data_o=fe_data_i.
- IDLE pass-through has zero latency, combinational.
- Mispredict with `rcnt`=N occupies 1 flush cycle followed by N push cycles. fe_ready_o returns high on cycle N+1 after the mispredict cycle.
- restore_busy_o is registered (state==RESTORE).
- Shadow update is visible in the snapshot taken the same cycle.
- Reset mid-restore returns to IDLE immediately. The RAS is reset by the same rst_ni.

## Configuration
- RAS_RESTORE_EN defined: behaviour as above.
- RAS_RESTORE_EN undefined:
  - No shadow, snap or RESTORE state is built; commit_* inputs are ignored.
  - mispredict_i only asserts ras_flush_o for that cycle and drops the frontend request.
  - restore_busy_o is tied to 0.

## Test plan
- IDLE pass-through: fe_push_i=1, fe_data_i=0x1000 -> ras_push_o=1, ras_data_o=0x1000, fe_ready_o=1 same cycle.
- Replay order (DEPTH=2): commit calls 0x100 then 0x200; mispredict -> cycle 0 ras_flush_o=1; cycle 1 push 0x100; cycle 2 push 0x200; cycle 3 fe_ready_o=1.
- Shadow overflow/underflow (DEPTH=2):
  - Commit calls 0xA, 0xB, 0xC, then mispredict -> replays 0xB, 0xC only.
  - Three commit returns on an empty shadow, then mispredict -> flush only, no pushes, IDLE next cycle.
- Simultaneous commit call+ret with cnt=1 (top 0x40, data 0x80), then mispredict -> single replay push of 0x80.
- Mispredict during RESTORE (cnt=2, reasserted on the first push cycle) -> flush that cycle, restart with 2 pushes. clear_i during RESTORE -> flush, IDLE next cycle, later mispredict pushes nothing.
- Macro off: commit calls 0x100, then mispredict -> ras_flush_o for 1 cycle, no pushes, restore_busy_o stays 0.

Source files
------------

// File: rtl/ras_restore_ctrl.sv
// ras_restore_ctrl: sits between the frontend predictor and the return
// address stack. Forwards speculative push/pop, keeps a committed shadow
// stack fed by the commit stage, and on a mispredict flushes the RAS and
// replays the shadow into it (oldest entry first) while stalling the frontend.
// Optional feature macro: RAS_RESTORE_EN. When undefined, no shadow or
// restore logic is built and a mispredict only flushes the RAS.
module ras_restore_ctrl #(
  parameter int DEPTH = 2,
  parameter int VLEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            mispredict_i,
  input  logic            fe_push_i,
  input  logic            fe_pop_i,
  input  logic [VLEN-1:0] fe_data_i,
  output logic            fe_ready_o,
  input  logic            commit_call_i,
  input  logic            commit_ret_i,
  input  logic [VLEN-1:0] commit_data_i,
  output logic            ras_flush_o,
  output logic            ras_push_o,
  output logic            ras_pop_o,
  output logic [VLEN-1:0] ras_data_o,
  output logic            restore_busy_o
);

`ifdef RAS_RESTORE_EN
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {S_IDLE, S_RESTORE} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [VLEN-1:0] r_shadow     [DEPTH];
  logic [VLEN-1:0] w_shadow_nxt [DEPTH];
  logic [VLEN-1:0] r_snap       [DEPTH];
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   r_rcnt;
  logic [CW-1:0]   w_rd_idx;
  logic [VLEN-1:0] w_replay_data;
  logic            w_snap_ld;
  logic            w_rcnt_dec;

  // Shadow stack after this cycle's commit update; entry 0 is the top.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_cnt_nxt    = r_cnt;
    if (commit_call_i && commit_ret_i) begin
      w_shadow_nxt[0] = commit_data_i;
    end else if (commit_call_i) begin
      for (int i = DEPTH - 1; i > 0; i--) w_shadow_nxt[i] = r_shadow[i-1];
      w_shadow_nxt[0] = commit_data_i;
      if (r_cnt != CW'(DEPTH)) w_cnt_nxt = r_cnt + CW'(1);
    end else if (commit_ret_i) begin
      for (int i = 0; i < DEPTH - 1; i++) w_shadow_nxt[i] = r_shadow[i+1];
      w_shadow_nxt[DEPTH-1] = '0;
      if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // Replay reads the oldest remaining snapshot entry, snap[rcnt-1].
  assign w_rd_idx = r_rcnt - CW'(1);

  // Select the replay entry without a narrowing array index.
  always_comb begin
    w_replay_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_rd_idx == CW'(i)) w_replay_data = r_snap[i];
    end
  end

  // Next-state and RAS-side outputs; clear beats mispredict beats state.
  always_comb begin
    w_state_nxt = r_state;
    fe_ready_o  = 1'b0;
    ras_flush_o = 1'b0;
    ras_push_o  = 1'b0;
    ras_pop_o   = 1'b0;
    ras_data_o  = fe_data_i;
    w_snap_ld   = 1'b0;
    w_rcnt_dec  = 1'b0;
    if (clear_i) begin
      ras_flush_o = 1'b1;
      w_state_nxt = S_IDLE;
    end else if (mispredict_i) begin
      ras_flush_o = 1'b1;
      w_snap_ld   = 1'b1;
      w_state_nxt = (w_cnt_nxt != '0) ? S_RESTORE : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          fe_ready_o = 1'b1;
          ras_push_o = fe_push_i;
          ras_pop_o  = fe_pop_i;
        end
        S_RESTORE: begin
          ras_push_o = 1'b1;
          ras_data_o = w_replay_data;
          w_rcnt_dec = 1'b1;
          if (r_rcnt == CW'(1)) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Shadow stack, snapshot and replay counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_rcnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_shadow[i] <= '0;
        r_snap[i]   <= '0;
      end
    end else if (clear_i) begin
      r_cnt  <= '0;
      r_rcnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_shadow[i] <= '0;
    end else begin
      r_shadow <= w_shadow_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_snap_ld) begin
        r_snap <= w_shadow_nxt;
        r_rcnt <= w_cnt_nxt;
      end else if (w_rcnt_dec) begin
        r_rcnt <= r_rcnt - CW'(1);
      end
    end
  end

  assign restore_busy_o = (r_state == S_RESTORE);

`else
  // Without restore support, nothing is stateful and commits are ignored.
  logic w_unused;
  assign w_unused = ^{clk_i, rst_ni, commit_call_i, commit_ret_i, commit_data_i};

  // Pass-through, with a one-cycle flush and dropped request on clear/mispredict.
  always_comb begin
    fe_ready_o  = 1'b0;
    ras_flush_o = 1'b0;
    ras_push_o  = 1'b0;
    ras_pop_o   = 1'b0;
    ras_data_o  = fe_data_i;
    if (clear_i || mispredict_i) begin
      ras_flush_o = 1'b1;
    end else begin
      fe_ready_o = 1'b1;
      ras_push_o = fe_push_i;
      ras_pop_o  = fe_pop_i;
    end
  end

  assign restore_busy_o = 1'b0;
`endif

endmodule
